// File: rtl/vred_seq_if.sv
// Handshake and data bundle between the reduction sequencer and its environment.
// The slave side is the sequencer; the master side is the surrounding logic and the reduction unit.
interface vred_seq_if #(
   parameter int DATA_WIDTH = 64,
   parameter int LEN_WIDTH  = 8
);
   logic                    start;
   logic [1:0]              sew;
   logic [8:0]              opSel;
   logic [LEN_WIDTH-1:0]    vlen_words;
   logic [DATA_WIDTH-1:0]   scalar;
   logic                    in_valid;
   logic [DATA_WIDTH-1:0]   in_data;
   logic                    in_ready;
   logic [2*DATA_WIDTH-1:0] red_vec0;
   logic                    red_en;
   logic [1:0]              red_sew;
   logic [8:0]              red_opSel;
   logic [DATA_WIDTH-1:0]   red_result;
   logic                    res_valid;
   logic [DATA_WIDTH-1:0]   res_data;
   logic                    busy;

   modport master (
      output start, sew, opSel, vlen_words, scalar, in_valid, in_data, red_result,
      input  in_ready, red_vec0, red_en, red_sew, red_opSel, res_valid, res_data, busy
   );

   modport slave (
      input  start, sew, opSel, vlen_words, scalar, in_valid, in_data, red_result,
      output in_ready, red_vec0, red_en, red_sew, red_opSel, res_valid, res_data, busy
   );
endinterface

// File: rtl/vred_seq.sv
// Reduction sequencer: folds words, then lanes, then the scalar seed through an external sum/min/max unit.
// VRED_PREFETCH_EN adds a one-entry input buffer so a word can be taken while a word fold is in flight.
module vred_seq #(
   parameter int DATA_WIDTH  = 64,
   parameter int LEN_WIDTH   = 8,
   parameter int RED_LATENCY = 1
) (
   input  logic      clk,
   input  logic      rst,
   vred_seq_if.slave bus
);
   typedef enum logic [3:0] {
      IDLE, LOAD_FIRST, LOAD, WAIT_W, FOLD_ISSUE, WAIT_F, SCALAR_ISSUE, WAIT_S, DONE
   } state_e;

   localparam int LAT_W = $clog2(RED_LATENCY + 1);
   localparam int SH_W  = $clog2(DATA_WIDTH) + 1;
   localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(RED_LATENCY - 1);

   state_e                  state_q, state_d;
   logic [DATA_WIDTH-1:0]   acc_q, acc_d;
   logic [DATA_WIDTH-1:0]   scalar_q, scalar_d;
   logic [DATA_WIDTH-1:0]   res_q, res_d;
   logic [LEN_WIDTH-1:0]    vlen_q, vlen_d;
   logic [LEN_WIDTH-1:0]    rem_q, rem_d;
   logic [1:0]              sew_q, sew_d;
   logic [1:0]              fold_k_q, fold_k_d;
   logic [8:0]              opsel_q, opsel_d;
   logic [LAT_W-1:0]        lat_q, lat_d;
   logic                    lat_done;
   logic [SH_W-1:0]         shamt;
   logic                    load_hit;
   logic [DATA_WIDTH-1:0]   load_dat;
   state_e                  after_words;
`ifdef VRED_PREFETCH_EN
   logic                    buf_vld_q, buf_vld_d;
   logic [DATA_WIDTH-1:0]   buf_dat_q, buf_dat_d;
`endif

   // Lane 0 of x at element width s, upper bits forced to zero.
   function automatic logic [DATA_WIDTH-1:0] lane0(input logic [1:0] s, input logic [DATA_WIDTH-1:0] x);
      logic [DATA_WIDTH-1:0] m;
      m = '1;
      if (s != 2'd3) m = m >> (DATA_WIDTH - (8 << s));
      return x & m;
   endfunction

   always_comb begin
      state_d  = state_q;
      acc_d    = acc_q;
      scalar_d = scalar_q;
      res_d    = res_q;
      vlen_d   = vlen_q;
      rem_d    = rem_q;
      sew_d    = sew_q;
      fold_k_d = fold_k_q;
      opsel_d  = opsel_q;
      lat_d    = lat_q;
      bus.in_ready = 1'b0;
      bus.red_en   = 1'b0;
      bus.red_vec0 = '0;
      lat_done     = (lat_q == LAT_LAST);
      shamt        = SH_W'(DATA_WIDTH / 2) >> fold_k_q;
      after_words  = (sew_q == 2'd3) ? SCALAR_ISSUE : FOLD_ISSUE;
`ifdef VRED_PREFETCH_EN
      buf_vld_d = buf_vld_q;
      buf_dat_d = buf_dat_q;
      load_hit  = buf_vld_q || bus.in_valid;
      load_dat  = buf_vld_q ? buf_dat_q : bus.in_data;
`else
      load_hit  = bus.in_valid;
      load_dat  = bus.in_data;
`endif

      unique case (state_q)
         IDLE: begin
            if (bus.start) begin
               sew_d    = bus.sew;
               opsel_d  = bus.opSel;
               vlen_d   = bus.vlen_words;
               scalar_d = bus.scalar;
               acc_d    = '0;
               rem_d    = '0;
               fold_k_d = '0;
               lat_d    = '0;
`ifdef VRED_PREFETCH_EN
               buf_vld_d = 1'b0;
`endif
               state_d  = (bus.vlen_words == '0) ? SCALAR_ISSUE : LOAD_FIRST;
            end
         end
         LOAD_FIRST: begin
            bus.in_ready = 1'b1;
            if (bus.in_valid) begin
               acc_d   = bus.in_data;
               rem_d   = vlen_q - LEN_WIDTH'(1);
               state_d = (vlen_q == LEN_WIDTH'(1)) ? after_words : LOAD;
            end
         end
         LOAD: begin
`ifdef VRED_PREFETCH_EN
            bus.in_ready = !buf_vld_q;
            buf_vld_d    = 1'b0;
`else
            bus.in_ready = 1'b1;
`endif
            if (load_hit) begin
               bus.red_en   = 1'b1;
               bus.red_vec0 = {load_dat, acc_q};
               lat_d        = '0;
               state_d      = WAIT_W;
            end
         end
         WAIT_W: begin
`ifdef VRED_PREFETCH_EN
            // Only prefetch while a word beyond the one in flight is still owed.
            if (!buf_vld_q && rem_q > LEN_WIDTH'(1)) begin
               bus.in_ready = 1'b1;
               if (bus.in_valid) begin
                  buf_vld_d = 1'b1;
                  buf_dat_d = bus.in_data;
               end
            end
`endif
            if (lat_done) begin
               acc_d   = bus.red_result;
               rem_d   = rem_q - LEN_WIDTH'(1);
               state_d = (rem_q == LEN_WIDTH'(1)) ? after_words : LOAD;
            end else begin
               lat_d = lat_q + 1'b1;
            end
         end
         FOLD_ISSUE: begin
            bus.red_en   = 1'b1;
            bus.red_vec0 = {acc_q >> shamt, acc_q};
            lat_d        = '0;
            state_d      = WAIT_F;
         end
         WAIT_F: begin
            if (lat_done) begin
               acc_d = bus.red_result;
               if (fold_k_q == 2'd2 - sew_q) begin
                  state_d = SCALAR_ISSUE;
               end else begin
                  fold_k_d = fold_k_q + 2'd1;
                  state_d  = FOLD_ISSUE;
               end
            end else begin
               lat_d = lat_q + 1'b1;
            end
         end
         SCALAR_ISSUE: begin
            // An empty vector reduces to the seed itself, no unit pass needed.
            if (vlen_q == '0) begin
               acc_d   = scalar_q;
               res_d   = lane0(sew_q, scalar_q);
               state_d = DONE;
            end else begin
               bus.red_en   = 1'b1;
               bus.red_vec0 = {scalar_q, acc_q};
               lat_d        = '0;
               state_d      = WAIT_S;
            end
         end
         WAIT_S: begin
            if (lat_done) begin
               acc_d   = bus.red_result;
               res_d   = lane0(sew_q, bus.red_result);
               state_d = DONE;
            end else begin
               lat_d = lat_q + 1'b1;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign bus.res_valid = (state_q == DONE);
   assign bus.res_data  = res_q;
   assign bus.busy      = (state_q != IDLE);
   assign bus.red_sew   = sew_q;
   assign bus.red_opSel = opsel_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         acc_q    <= '0;
         scalar_q <= '0;
         res_q    <= '0;
         vlen_q   <= '0;
         rem_q    <= '0;
         sew_q    <= '0;
         fold_k_q <= '0;
         opsel_q  <= '0;
         lat_q    <= '0;
`ifdef VRED_PREFETCH_EN
         buf_vld_q <= 1'b0;
         buf_dat_q <= '0;
`endif
      end else begin
         state_q  <= state_d;
         acc_q    <= acc_d;
         scalar_q <= scalar_d;
         res_q    <= res_d;
         vlen_q   <= vlen_d;
         rem_q    <= rem_d;
         sew_q    <= sew_d;
         fold_k_q <= fold_k_d;
         opsel_q  <= opsel_d;
         lat_q    <= lat_d;
`ifdef VRED_PREFETCH_EN
         buf_vld_q <= buf_vld_d;
         buf_dat_q <= buf_dat_d;
`endif
      end
   end
endmodule

// File: tb/tb_vred_seq.sv
// Directed bench for vred_seq with a lane-wise sum/min/max reduction unit model (latency 1).
module tb_vred_seq;
   localparam int DW = 64;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   vred_seq_if #(.DATA_WIDTH(DW), .LEN_WIDTH(8)) vif ();

   vred_seq #(.DATA_WIDTH(DW), .LEN_WIDTH(8), .RED_LATENCY(1)) dut (
      .clk (clk),
      .rst (rst),
      .bus (vif.slave)
   );

   int n_tests = 0;
   int n_fail  = 0;
   int en_cnt  = 0;
   int acc_cnt = 0;
   int rv_cnt  = 0;
   int viol    = 0;

   // Reduction unit model; opSel[3]=1 sum, else opSel[0]=1 unsigned max, opSel[0]=0 unsigned min.
   function automatic logic [63:0] red_fn(input logic [127:0] v, input logic [1:0] s, input logic [8:0] op);
      logic [63:0] a, b, r, m, la, lb, lr;
      int w;
      a = v[63:0];
      b = v[127:64];
      w = 8 << s;
      r = '0;
      m = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
      for (int i = 0; i < 64 / w; i++) begin
         la = (a >> (i * w)) & m;
         lb = (b >> (i * w)) & m;
         if (op[3])      lr = (la + lb) & m;
         else if (op[0]) lr = (la > lb) ? la : lb;
         else            lr = (la < lb) ? la : lb;
         r = r | (lr << (i * w));
      end
      return r;
   endfunction

   always @(posedge clk) begin
      if (!rst) vif.red_result <= '0;
      else if (vif.red_en) vif.red_result <= red_fn(vif.red_vec0, vif.red_sew, vif.red_opSel);
      if (vif.red_en) en_cnt <= en_cnt + 1;
      if (vif.in_valid && vif.in_ready) acc_cnt <= acc_cnt + 1;
      if (vif.res_valid) rv_cnt <= rv_cnt + 1;
      if (!vif.red_en && vif.red_vec0 != '0) viol <= viol + 1;
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic start_op(input logic [1:0] s, input logic [8:0] op, input logic [7:0] vl,
                           input logic [63:0] sc, input bit hold);
      @(negedge clk);
      vif.start = 1'b1;
      vif.sew = s;
      vif.opSel = op;
      vif.vlen_words = vl;
      vif.scalar = sc;
      @(negedge clk);
      if (!hold) vif.start = 1'b0;
   endtask

   task automatic feed_word(input logic [63:0] d, input bit junk_after);
      int t;
      t = 0;
      vif.in_valid = 1'b1;
      vif.in_data = d;
      while (!vif.in_ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (t >= 50) chk("feed_timeout", 64'd1, 64'd0);
      @(negedge clk);
      vif.in_valid = junk_after;
      vif.in_data = junk_after ? 64'hDEAD_BEEF_0BAD_F00D : 64'd0;
   endtask

   task automatic finish_op(input string nm, input logic [63:0] exp_res, input int exp_en,
                            input int exp_acc, input int en0, input int acc0, input int rv0,
                            output int lat);
      lat = 0;
      while (!vif.res_valid && lat < 2000) begin
         @(negedge clk);
         lat++;
      end
      if (lat >= 2000) chk({nm, "_timeout"}, 64'd1, 64'd0);
      vif.start = 1'b0;
      vif.in_valid = 1'b0;
      chk({nm, "_res"}, vif.res_data, exp_res);
      @(negedge clk);
      chk({nm, "_hold"}, vif.res_data, exp_res);
      chk({nm, "_en_cnt"}, 64'(en_cnt - en0), 64'(exp_en));
      chk({nm, "_acc_cnt"}, 64'(acc_cnt - acc0), 64'(exp_acc));
      chk({nm, "_rv_cnt"}, 64'(rv_cnt - rv0), 64'd1);
   endtask

   initial begin
      int en0, acc0, rv0, lat;
      vif.start = 1'b0;
      vif.sew = '0;
      vif.opSel = '0;
      vif.vlen_words = '0;
      vif.scalar = '0;
      vif.in_valid = 1'b0;
      vif.in_data = '0;
      repeat (2) @(negedge clk);
      chk("rst_busy", 64'(vif.busy), 64'd0);
      chk("rst_in_ready", 64'(vif.in_ready), 64'd0);
      chk("rst_red_en", 64'(vif.red_en), 64'd0);
      chk("rst_res_valid", 64'(vif.res_valid), 64'd0);
      chk("rst_res_data", vif.res_data, 64'd0);
      chk("rst_red_vec0", 64'(vif.red_vec0 != '0), 64'd0);
      rst = 1'b1;

      // 32b sum over two words plus seed 10
      en0 = en_cnt; acc0 = acc_cnt; rv0 = rv_cnt;
      start_op(2'd2, 9'h008, 8'd2, 64'd10, 1'b0);
      feed_word(64'h00000002_00000001, 1'b0);
      feed_word(64'h00000004_00000003, 1'b0);
      finish_op("sum32", 64'd20, 3, 2, en0, acc0, rv0, lat);

      // 8b sum of one word: three lane folds then the seed
      en0 = en_cnt; acc0 = acc_cnt; rv0 = rv_cnt;
      start_op(2'd0, 9'h008, 8'd1, 64'd0, 1'b0);
      feed_word(64'h0807060504030201, 1'b0);
      finish_op("sum8", 64'h24, 4, 1, en0, acc0, rv0, lat);

      // 64b max, no lane folds
      en0 = en_cnt; acc0 = acc_cnt; rv0 = rv_cnt;
      start_op(2'd3, 9'h001, 8'd3, 64'd7, 1'b0);
      feed_word(64'd5, 1'b0);
      feed_word(64'd9, 1'b0);
      feed_word(64'd2, 1'b0);
      finish_op("max64", 64'd9, 3, 3, en0, acc0, rv0, lat);
      chk("max64_red_opSel", 64'(vif.red_opSel), 64'h001);
      chk("max64_red_sew", 64'(vif.red_sew), 64'd3);

      // 16b min: lanes 7,3,9,4 with seed 5
      en0 = en_cnt; acc0 = acc_cnt; rv0 = rv_cnt;
      start_op(2'd1, 9'h000, 8'd1, 64'd5, 1'b0);
      feed_word(64'h0004_0009_0003_0007, 1'b0);
      finish_op("min16", 64'd3, 3, 1, en0, acc0, rv0, lat);

      // empty vector returns masked seed two cycles after start
      en0 = en_cnt; acc0 = acc_cnt; rv0 = rv_cnt;
      start_op(2'd1, 9'h008, 8'd0, 64'hFFFF_FFFF_FFFF_0042, 1'b0);
      finish_op("empty", 64'h0042, 0, 0, en0, acc0, rv0, lat);
      chk("empty_latency", 64'(lat + 1), 64'd2);

      // reset in WAIT_W of a 4-word op
      rv0 = rv_cnt;
      start_op(2'd2, 9'h008, 8'd4, 64'd0, 1'b0);
      feed_word(64'd1, 1'b0);
      feed_word(64'd2, 1'b0);
      chk("wait_w_busy", 64'(vif.busy), 64'd1);
`ifdef VRED_PREFETCH_EN
      chk("wait_w_in_ready", 64'(vif.in_ready), 64'd1);
`else
      chk("wait_w_in_ready", 64'(vif.in_ready), 64'd0);
`endif
      rst = 1'b0;
      #1;
      chk("midrst_busy", 64'(vif.busy), 64'd0);
      chk("midrst_in_ready", 64'(vif.in_ready), 64'd0);
      chk("midrst_red_en", 64'(vif.red_en), 64'd0);
      chk("midrst_res_data", vif.res_data, 64'd0);
      chk("midrst_red_sew", 64'(vif.red_sew), 64'd0);
      @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      chk("midrst_no_res_valid", 64'(rv_cnt - rv0), 64'd0);
      en0 = en_cnt; acc0 = acc_cnt; rv0 = rv_cnt;
      start_op(2'd2, 9'h008, 8'd2, 64'd10, 1'b0);
      feed_word(64'h00000002_00000001, 1'b0);
      feed_word(64'h00000004_00000003, 1'b0);
      finish_op("after_rst", 64'd20, 3, 2, en0, acc0, rv0, lat);

      // start held high and junk in_valid through fold/scalar phases
      en0 = en_cnt; acc0 = acc_cnt; rv0 = rv_cnt;
      start_op(2'd2, 9'h008, 8'd2, 64'd10, 1'b1);
      feed_word(64'h00000002_00000001, 1'b1);
      feed_word(64'h00000004_00000003, 1'b1);
      chk("hold_in_ready_last", 64'(vif.in_ready), 64'd0);
      finish_op("hold", 64'd20, 3, 2, en0, acc0, rv0, lat);

      // maximum word count without counter wrap
      en0 = en_cnt; acc0 = acc_cnt; rv0 = rv_cnt;
      start_op(2'd3, 9'h008, 8'd255, 64'd0, 1'b0);
      for (int i = 0; i < 255; i++) feed_word(64'd1, 1'b0);
      finish_op("max_len", 64'd255, 255, 255, en0, acc0, rv0, lat);

      chk("red_vec0_idle_zero", 64'(viol), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
